mem_stage: RTL and testbench

//  Memory-access stage of the 5-stage RV32 pipeline; consumes the EX/MEM values produced by execute.

---
 rtl/pipeline_pkg.sv | 34 +++
 rtl/memwb_reg.sv | 31 +++
 rtl/mem_stage.sv | 168 ++++++++++++++++
 tb/tb_mem_stage.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the RV32 pipeline memory stage.
//   PL_XLEN        : datapath width that the MEM/WB record is sized for
//   RES_*          : ResultSrc encodings (2'b11 is reserved and behaves as ALU)
//   mem_state_t    : memory-access FSM states
//   memwb_t        : MEM/WB pipeline record
//   norm_result_src: maps the reserved ResultSrc code onto RES_ALU
package pipeline_pkg;

    localparam int unsigned PL_XLEN = 32;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_RSP
    } mem_state_t;

    typedef struct packed {
        logic [PL_XLEN-1:0] alu_result;
        logic [PL_XLEN-1:0] read_data;
        logic [PL_XLEN-1:0] pc_plus4;
        logic [4:0]         rd;
        logic               reg_write;
        logic [1:0]         result_src;
    } memwb_t;

    function automatic logic [1:0] norm_result_src(input logic [1:0] src);
        return (src == 2'b11) ? RES_ALU : src;
    endfunction

endpackage

// File: rtl/memwb_reg.sv
// MEM/WB pipeline register.
//   clk, reset : rising-edge clock, synchronous active-high reset (clears record)
//   bubble_i   : 1 = insert a bubble (drop reg_write, hold other fields),
//                0 = load d_i
//   d_i        : record presented by the memory stage
//   q_o        : registered record
module memwb_reg
    import pipeline_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   bubble_i,
    input  memwb_t d_i,
    output memwb_t q_o
);

    memwb_t wb_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_q <= '0;
        end else if (bubble_i) begin
            wb_q.reg_write <= 1'b0;
        end else begin
            wb_q <= d_i;
        end
    end

    assign q_o = wb_q;

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage of the 5-stage RV32 pipeline.
//   Inputs  : EX/MEM values (ALUResultM, WriteDataM, PCPlus4M, RdM, RegWriteM,
//             MemWriteM, ResultSrcM), data-memory handshake (dmem_ready,
//             dmem_rvalid, dmem_rdata)
//   Outputs : data-memory request (dmem_req, dmem_we, dmem_addr, dmem_wdata),
//             StallM to hold upstream, MemFaultM 1-cycle fault pulse,
//             MEM/WB register (ALUResultW, ReadDataW, PCPlus4W, RdW,
//             RegWriteW, ResultSrcW)
// XLEN must equal pipeline_pkg::PL_XLEN since the MEM/WB record is sized by it.
module mem_stage
    import pipeline_pkg::*;
#(
    parameter int unsigned XLEN    = PL_XLEN,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [XLEN-1:0] WriteDataM,
    input  logic [XLEN-1:0] PCPlus4M,
    input  logic [4:0]      RdM,
    input  logic            RegWriteM,
    input  logic            MemWriteM,
    input  logic [1:0]      ResultSrcM,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ready,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            StallM,
    output logic            MemFaultM,
    output logic [XLEN-1:0] ALUResultW,
    output logic [XLEN-1:0] ReadDataW,
    output logic [XLEN-1:0] PCPlus4W,
    output logic [4:0]      RdW,
    output logic            RegWriteW,
    output logic [1:0]      ResultSrcW
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    mem_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic   is_store, is_load, mem_op, misaligned, expired;
    logic   req, stall, fault;
    memwb_t wb_d, wb_q;

    // A store takes precedence over the ResultSrc field when both say "memory".
    assign is_store   = MemWriteM;
    assign is_load    = !MemWriteM && (ResultSrcM == RES_MEM);
    assign mem_op     = is_store || is_load;
    assign misaligned = |ALUResultM[1:0];
    assign expired    = (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The counter defaults to zero so it clears on every state change; it
    // only advances while the FSM stays in REQ or WAIT_RSP. A handshake is
    // checked before expiry so it wins on the last cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        req     = 1'b0;
        stall   = 1'b0;
        fault   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mem_op) begin
                    if (misaligned) begin
                        fault = 1'b1;
                    end else begin
                        req = 1'b1;
                        if (!dmem_ready) begin
                            state_d = REQ;
                            stall   = 1'b1;
                        end else if (is_load) begin
                            state_d = WAIT_RSP;
                            stall   = 1'b1;
                        end
                    end
                end
            end
            REQ: begin
                req = 1'b1;
                if (dmem_ready) begin
                    if (is_load) begin
                        state_d = WAIT_RSP;
                        stall   = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (expired) begin
                    state_d = IDLE;
                    fault   = 1'b1;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_RSP: begin
                if (dmem_rvalid) begin
                    state_d = IDLE;
                end else if (expired) begin
                    state_d = IDLE;
                    fault   = 1'b1;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // Outputs are forced low while reset is held.
        if (reset) begin
            req   = 1'b0;
            stall = 1'b0;
            fault = 1'b0;
        end
    end

    always_comb begin
        dmem_req   = req;
        dmem_we    = req && is_store;
        dmem_addr  = req ? {ALUResultM[XLEN-1:2], 2'b00} : '0;
        dmem_wdata = req ? WriteDataM : '0;
        StallM     = stall;
        MemFaultM  = fault;
    end

    // Record loaded in the retiring cycle; a faulting op retires without a write.
    always_comb begin
        wb_d            = '0;
        wb_d.alu_result = ALUResultM;
        wb_d.read_data  = dmem_rdata;
        wb_d.pc_plus4   = PCPlus4M;
        wb_d.rd         = RdM;
        wb_d.reg_write  = RegWriteM && !fault;
        wb_d.result_src = norm_result_src(ResultSrcM);
    end

    memwb_reg u_memwb (
        .clk      (clk),
        .reset    (reset),
        .bubble_i (stall),
        .d_i      (wb_d),
        .q_o      (wb_q)
    );

    assign ALUResultW = wb_q.alu_result;
    assign ReadDataW  = wb_q.read_data;
    assign PCPlus4W   = wb_q.pc_plus4;
    assign RdW        = wb_q.rd;
    assign RegWriteW  = wb_q.reg_write;
    assign ResultSrcW = wb_q.result_src;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios followed by random
// operations, each compared against expectations computed from the op kind,
// the chosen ready/rvalid latencies and the timeout budget.
module tb_mem_stage;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RdM;
    logic        RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ready, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        StallM, MemFaultM;
    logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
    logic [4:0]  RdW;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;

    int total = 0;
    int bad   = 0;

    mem_stage #(.XLEN(32), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .PCPlus4M   (PCPlus4M),
        .RdM        (RdM),
        .RegWriteM  (RegWriteM),
        .MemWriteM  (MemWriteM),
        .ResultSrcM (ResultSrcM),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ready (dmem_ready),
        .dmem_rvalid(dmem_rvalid),
        .dmem_rdata (dmem_rdata),
        .StallM     (StallM),
        .MemFaultM  (MemFaultM),
        .ALUResultW (ALUResultW),
        .ReadDataW  (ReadDataW),
        .PCPlus4W   (PCPlus4W),
        .RdW        (RdW),
        .RegWriteW  (RegWriteW),
        .ResultSrcW (ResultSrcW)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // kind: 0 ALU, 1 PC+4, 2 reserved ResultSrc, 3 store, 4 load.
    // r: cycle (from issue) at which ready pulses; v: rvalid delay after acceptance.
    // Called and returns at posedge+1.
    task automatic do_op(input int kind, input logic [31:0] addr, input int r,
                         input int v, input bit stray, input logic [4:0] rd,
                         input logic rw, input logic [31:0] wdata, input logic [31:0] rdata);
        logic [31:0] pc;
        bit          memop, mis, ok_load, done_seen;
        int          exp_done, exp_fault, exp_req;
        int          c, dc, n_stall, n_fault, n_req, stab_err, bub_err;
        logic [1:0]  exp_src;

        pc         = $urandom;
        ALUResultM = addr;
        WriteDataM = wdata;
        PCPlus4M   = pc;
        RdM        = rd;
        RegWriteM  = (kind == 3) ? 1'b0 : rw;
        MemWriteM  = (kind == 3);
        ResultSrcM = (kind == 1) ? 2'b10 : (kind == 2) ? 2'b11 : (kind == 4) ? 2'b01 : 2'b00;
        exp_src    = (kind == 1) ? 2'b10 : (kind == 4) ? 2'b01 : 2'b00;

        memop   = (kind >= 3);
        mis     = memop && (addr[1:0] != 2'b00);
        ok_load = 1'b0;
        if (!memop || mis) begin
            exp_done = 0; exp_fault = mis ? 1 : 0; exp_req = 0;
        end else if (r > TO) begin
            exp_done = TO; exp_fault = 1; exp_req = TO + 1;
        end else if (kind == 3) begin
            exp_done = r; exp_fault = 0; exp_req = r + 1;
        end else if (v > TO) begin
            exp_done = r + TO; exp_fault = 1; exp_req = r + 1;
        end else begin
            exp_done = r + v; exp_fault = 0; exp_req = r + 1; ok_load = 1'b1;
        end

        c = 0; dc = -1; done_seen = 1'b0;
        n_stall = 0; n_fault = 0; n_req = 0; stab_err = 0; bub_err = 0;
        while (!done_seen && c < 40) begin
            dmem_ready  = (c == r);
            dmem_rvalid = (stray && c == 0) || (kind == 4 && c == r + v);
            dmem_rdata  = (kind == 4 && c == r + v) ? rdata : $urandom;
            if (c > 0 && RegWriteW !== 1'b0) bub_err++;
            @(negedge clk);
            if (StallM === 1'b1) n_stall++;
            if (MemFaultM === 1'b1) n_fault++;
            if (dmem_req === 1'b1) begin
                n_req++;
                if (dmem_addr !== addr || dmem_wdata !== wdata || dmem_we !== (kind == 3))
                    stab_err++;
            end
            if (StallM !== 1'b1) begin
                done_seen = 1'b1;
                dc = c;
            end else begin
                @(posedge clk); #1;
                c++;
            end
        end
        @(posedge clk); #1;
        dmem_ready  = 1'b0;
        dmem_rvalid = 1'b0;

        chk("op_completes", {31'd0, done_seen}, 32'd1);
        chk("retire_cycle", dc, exp_done);
        chk("stall_cycles", n_stall, exp_done);
        chk("fault_pulses", n_fault, exp_fault);
        chk("req_cycles", n_req, exp_req);
        chk("req_stable", stab_err, 0);
        chk("bubble_regwrite", bub_err, 0);
        chk("ALUResultW", ALUResultW, addr);
        chk("PCPlus4W", PCPlus4W, pc);
        chk("RdW", {27'd0, RdW}, {27'd0, rd});
        chk("RegWriteW", {31'd0, RegWriteW}, {31'd0, (kind != 3) && rw && (exp_fault == 0)});
        chk("ResultSrcW", {30'd0, ResultSrcW}, {30'd0, exp_src});
        if (ok_load) chk("ReadDataW", ReadDataW, rdata);
    endtask

    task automatic rnd_op(input int kind, input logic [31:0] addr, input int r, input int v);
        do_op(kind, addr, r, v, 1'b0, 5'($urandom), 1'($urandom), $urandom, $urandom);
    endtask

    initial begin
        int          kind, r, v, s;
        logic [31:0] a;

        reset = 1'b1;
        ALUResultM = '0; WriteDataM = '0; PCPlus4M = '0; RdM = '0;
        RegWriteM = 1'b0; MemWriteM = 1'b0; ResultSrcM = 2'b00;
        dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ALUResultW", ALUResultW, 0);
        chk("rst_ReadDataW", ReadDataW, 0);
        chk("rst_RegWriteW", {31'd0, RegWriteW}, 0);
        @(negedge clk);
        chk("rst_req", {31'd0, dmem_req}, 0);
        chk("rst_stall", {31'd0, StallM}, 0);
        chk("rst_fault", {31'd0, MemFaultM}, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // 1: ALU op
        do_op(0, 32'h1234, 0, 1, 1'b0, 5'd5, 1'b1, 32'h0, 32'h0);
        // 2: store, ready after 3 cycles
        do_op(3, 32'h100, 3, 1, 1'b0, 5'd0, 1'b0, 32'hDEADBEEF, 32'h0);
        // 3: load, ready immediately, rvalid 2 cycles later
        do_op(4, 32'h200, 0, 2, 1'b0, 5'd7, 1'b1, 32'h0, 32'hCAFEF00D);
        // 4: misaligned load
        do_op(4, 32'h203, 0, 1, 1'b0, 5'd8, 1'b1, 32'h0, 32'h0);
        // 5: load with no response, then stray rvalid on a following ALU op
        do_op(4, 32'h300, 0, 99, 1'b0, 5'd9, 1'b1, 32'h0, 32'h0);
        do_op(0, 32'h55, 0, 1, 1'b1, 5'd10, 1'b1, 32'h0, 32'h0);
        // Handshake on the final budget cycle wins over expiry
        do_op(3, 32'h400, TO, 1, 1'b0, 5'd0, 1'b0, 32'h11223344, 32'h0);
        do_op(4, 32'h404, 1, TO, 1'b0, 5'd11, 1'b1, 32'h0, 32'h0BADF00D);
        // Store that never gets ready times out
        do_op(3, 32'h408, 99, 1, 1'b0, 5'd0, 1'b0, 32'h5A5A5A5A, 32'h0);

        // 6: reset while in WAIT_RSP
        ALUResultM = 32'h500; MemWriteM = 1'b0; ResultSrcM = 2'b01;
        RegWriteM = 1'b1; RdM = 5'd12; dmem_ready = 1'b1;
        @(posedge clk); #1;
        dmem_ready = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        reset = 1'b1; ResultSrcM = 2'b00; RegWriteM = 1'b0;
        dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF0000;
        @(negedge clk);
        chk("midrst_stall", {31'd0, StallM}, 0);
        @(posedge clk); #1;
        reset = 1'b0; dmem_rvalid = 1'b0;
        chk("midrst_ALUResultW", ALUResultW, 0);
        chk("midrst_ReadDataW", ReadDataW, 0);
        chk("midrst_PCPlus4W", PCPlus4W, 0);
        chk("midrst_RdW", {27'd0, RdW}, 0);
        chk("midrst_RegWriteW", {31'd0, RegWriteW}, 0);
        chk("midrst_ResultSrcW", {30'd0, ResultSrcW}, 0);
        @(negedge clk);
        chk("midrst_req", {31'd0, dmem_req}, 0);
        chk("midrst_stall2", {31'd0, StallM}, 0);
        @(posedge clk); #1;
        do_op(4, 32'h600, 1, 2, 1'b0, 5'd13, 1'b1, 32'h0, 32'h13579BDF);

        // Random back-to-back operations
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 4);
            a    = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
            s = $urandom_range(0, 9);
            r = (s == 0) ? 20 : (s == 1) ? TO : $urandom_range(0, 4);
            s = $urandom_range(0, 9);
            v = (s == 0) ? 99 : (s == 1) ? TO : $urandom_range(1, 4);
            rnd_op(kind, a, r, v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
